// File: rtl/rca_pkg.sv
// Shared arithmetic-lab definitions: default operand/digit widths, FSM states,
// and the counter-width helper used by the digit-serial datapaths.
package rca_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned DIGIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A counter is always at least one bit wide, even for a single-digit operation.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rbs_digit.sv
// Combinational DIGIT-bit ripple-borrow chain of full subtractors:
// diff = x - y - bin, and bout is the borrow out of the top bit.
module rbs_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);

    logic brw_c;

    always_comb begin
        diff  = '0;
        brw_c = bin;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            diff[i] = x[i] ^ y[i] ^ brw_c;
            brw_c   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw_c);
        end
        bout = brw_c;
    end

endmodule

// File: rtl/rbs_serial_clk.sv
// Digit-serial ripple-borrow subtractor: d = a - b - bi over WIDTH bits,
// DIGIT bits per clock, with a start/busy/done handshake.
module rbs_serial_clk
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DIGIT = DIGIT_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf
);

    localparam int unsigned   N    = WIDTH / DIGIT;
    localparam int unsigned   CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_sr_nxt;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             a_msb, b_msb;
    logic [DIGIT-1:0] dig_diff;
    logic             dig_bout;
    logic             load, last;

    rbs_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (a_sr[DIGIT-1:0]),
        .y    (b_sr[DIGIT-1:0]),
        .bin  (brw),
        .diff (dig_diff),
        .bout (dig_bout)
    );

    // Each digit result enters at the MSB end so the full word lines up after N steps.
    assign d_sr_nxt = (d_sr >> DIGIT) | (WIDTH'(dig_diff) << (WIDTH - DIGIT));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = (state == RUN) && (cnt == LAST);
        case (state)
            IDLE: if (start) begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            d_sr  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            d     <= '0;
            bo    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            d_sr  <= '0;
            brw   <= bi;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN) begin
            a_sr <= a_sr >> DIGIT;
            b_sr <= b_sr >> DIGIT;
            d_sr <= d_sr_nxt;
            brw  <= dig_bout;
            cnt  <= cnt + CW'(1);
            // Operand MSBs were shifted out long ago; overflow uses the copies taken at load.
            if (last) begin
                d   <= d_sr_nxt;
                bo  <= dig_bout;
                ovf <= (a_msb ^ b_msb) & (d_sr_nxt[WIDTH-1] ^ a_msb);
            end
        end
    end

endmodule
